route_demux2_32: RTL and testbench

ROUTE_DEMUX2_32 -- requirements
Module: route_demux2_32

---
 rtl/route_demux2_32.sv | 118 +++++++++++
 tb/tb_route_demux2_32.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/route_demux2_32.sv
// Two-way demultiplexer: routes 32-bit words into one of two independent FIFO queues.
// Optional transfer counters are compiled in with the ROUTE_DEMUX2_32_CNT_EN macro.
module route_demux2_32 #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_sel,
  input  logic [31:0]                   in_data,
  output logic                          out0_valid,
  input  logic                          out0_ready,
  output logic [31:0]                   out0_data,
  output logic [$clog2(FIFO_DEPTH):0]   out0_level,
  output logic                          out1_valid,
  input  logic                          out1_ready,
  output logic [31:0]                   out1_data,
  output logic [$clog2(FIFO_DEPTH):0]   out1_level
`ifdef ROUTE_DEMUX2_32_CNT_EN
  ,
  input  logic                          cnt_clr,
  output logic [15:0]                   cnt0,
  output logic [15:0]                   cnt1
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  logic [PW-1:0] wr_q  [2];
  logic [PW-1:0] wr_d  [2];
  logic [PW-1:0] rd_q  [2];
  logic [PW-1:0] rd_d  [2];
  logic [LW-1:0] lvl_q [2];
  logic [LW-1:0] lvl_d [2];
  logic [31:0]   mem_q [2][FIFO_DEPTH];

  logic [1:0] full;
  logic [1:0] vld;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_rdy;

  assign out_rdy = {out1_ready, out0_ready};

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      full[k] = (lvl_q[k] == LW'(FIFO_DEPTH));
      vld[k]  = (lvl_q[k] != '0);
    end
  end

  // No full-bypass: a full queue refuses the push even if it pops this cycle.
  assign in_ready = rst_n & ~full[in_sel];

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      push[k]  = in_valid & in_ready & (in_sel == 1'(k));
      pop[k]   = vld[k] & out_rdy[k] & rst_n;
      wr_d[k]  = push[k] ? wr_q[k] + PW'(1) : wr_q[k];
      rd_d[k]  = pop[k]  ? rd_q[k] + PW'(1) : rd_q[k];
      lvl_d[k] = lvl_q[k];
      case ({push[k], pop[k]})
        2'b10:   lvl_d[k] = lvl_q[k] + LW'(1);
        2'b01:   lvl_d[k] = lvl_q[k] - LW'(1);
        default: lvl_d[k] = lvl_q[k];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        wr_q[k]  <= '0;
        rd_q[k]  <= '0;
        lvl_q[k] <= '0;
      end else begin
        wr_q[k]  <= wr_d[k];
        rd_q[k]  <= rd_d[k];
        lvl_q[k] <= lvl_d[k];
      end
    end
  end

  // Storage is not reset; outputs are masked by valid so stale entries never leak.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (push[k]) mem_q[k][wr_q[k]] <= in_data;
    end
  end

  assign out0_valid = vld[0];
  assign out1_valid = vld[1];
  assign out0_data  = vld[0] ? mem_q[0][rd_q[0]] : 32'h0;
  assign out1_data  = vld[1] ? mem_q[1][rd_q[1]] : 32'h0;
  assign out0_level = lvl_q[0];
  assign out1_level = lvl_q[1];

`ifdef ROUTE_DEMUX2_32_CNT_EN
  logic [15:0] cnt_q [2];

  // Clear wins over increment; counts saturate at all-ones.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n || cnt_clr) begin
        cnt_q[k] <= '0;
      end else if (pop[k] && (cnt_q[k] != 16'hFFFF)) begin
        cnt_q[k] <= cnt_q[k] + 16'd1;
      end
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
`endif

endmodule

// File: tb/tb_route_demux2_32.sv
// Directed table-driven bench for route_demux2_32 at FIFO_DEPTH=2, with hand-written
// streaming and (when ROUTE_DEMUX2_32_CNT_EN is defined) counter sequences.
module tb_route_demux2_32;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_sel;
  logic [31:0] in_data;
  logic        out0_valid, out0_ready, out1_valid, out1_ready;
  logic [31:0] out0_data, out1_data;
  logic [1:0]  out0_level, out1_level;
`ifdef ROUTE_DEMUX2_32_CNT_EN
  logic        cnt_clr;
  logic [15:0] cnt0, cnt1;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  route_demux2_32 #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out0_level (out0_level),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out1_level (out1_level)
`ifdef ROUTE_DEMUX2_32_CNT_EN
    ,
    .cnt_clr    (cnt_clr),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        v;
    logic        sel;
    logic [31:0] d;
    logic        r0;
    logic        r1;
    logic [70:0] exp;
  } vec_t;

  // Expected observation: {in_ready, out0_valid, out0_data, out0_level, out1_valid, out1_data, out1_level}
  function automatic logic [70:0] ex(input logic rdy, input logic [31:0] d0, input logic [1:0] l0,
                                     input logic [31:0] d1, input logic [1:0] l1);
    return {rdy, (l0 != 2'd0), d0, l0, (l1 != 2'd0), d1, l1};
  endfunction

  function automatic vec_t mk(input logic r, input logic v, input logic s, input logic [31:0] d,
                              input logic a0, input logic a1, input logic [70:0] e);
    vec_t t;
    t.rst_n = r; t.v = v; t.sel = s; t.d = d; t.r0 = a0; t.r1 = a1; t.exp = e;
    return t;
  endfunction

  function automatic logic [70:0] observed();
    return {in_ready, out0_valid, out0_data, out0_level, out1_valid, out1_data, out1_level};
  endfunction

  task automatic drive(input logic r, input logic v, input logic s, input logic [31:0] d,
                       input logic a0, input logic a1);
    @(negedge clk);
    rst_n = r; in_valid = v; in_sel = s; in_data = d; out0_ready = a0; out1_ready = a1;
    #1;
  endtask

  task automatic cmp(input string nm, input logic [70:0] act, input logic [70:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  vec_t tbl[27];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
`ifdef ROUTE_DEMUX2_32_CNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);

    // reset state and release
    tbl[0]  = mk(0, 0, 0, 32'h0,         1, 1, ex(0, 32'h0, 0, 32'h0, 0));
    tbl[1]  = mk(1, 0, 0, 32'h0,         1, 1, ex(1, 32'h0, 0, 32'h0, 0));
    // routing
    tbl[2]  = mk(1, 1, 0, 32'hA5A5_0001, 1, 1, ex(1, 32'h0, 0, 32'h0, 0));
    tbl[3]  = mk(1, 1, 1, 32'h5A5A_0002, 1, 1, ex(1, 32'hA5A5_0001, 1, 32'h0, 0));
    tbl[4]  = mk(1, 0, 1, 32'h0,         1, 1, ex(1, 32'h0, 0, 32'h5A5A_0002, 1));
    tbl[5]  = mk(1, 0, 1, 32'h0,         1, 1, ex(1, 32'h0, 0, 32'h0, 0));
    // fill, stall, full-with-pop
    tbl[6]  = mk(1, 1, 0, 32'h1111_1111, 0, 1, ex(1, 32'h0, 0, 32'h0, 0));
    tbl[7]  = mk(1, 1, 0, 32'h2222_2222, 0, 1, ex(1, 32'h1111_1111, 1, 32'h0, 0));
    tbl[8]  = mk(1, 1, 0, 32'h3333_3333, 0, 1, ex(0, 32'h1111_1111, 2, 32'h0, 0));
    tbl[9]  = mk(1, 1, 0, 32'h3333_3333, 1, 1, ex(0, 32'h1111_1111, 2, 32'h0, 0));
    tbl[10] = mk(1, 1, 0, 32'h3333_3333, 1, 1, ex(1, 32'h2222_2222, 1, 32'h0, 0));
    tbl[11] = mk(1, 0, 0, 32'h0,         1, 1, ex(1, 32'h3333_3333, 1, 32'h0, 0));
    tbl[12] = mk(1, 0, 0, 32'h0,         1, 1, ex(1, 32'h0, 0, 32'h0, 0));
    // independence: port 0 full and stalled
    tbl[13] = mk(1, 1, 0, 32'h4444_4444, 0, 1, ex(1, 32'h0, 0, 32'h0, 0));
    tbl[14] = mk(1, 1, 0, 32'h5555_5555, 0, 1, ex(1, 32'h4444_4444, 1, 32'h0, 0));
    tbl[15] = mk(1, 1, 1, 32'h6666_6666, 0, 1, ex(1, 32'h4444_4444, 2, 32'h0, 0));
    tbl[16] = mk(1, 1, 1, 32'h7777_7777, 0, 1, ex(1, 32'h4444_4444, 2, 32'h6666_6666, 1));
    tbl[17] = mk(1, 1, 1, 32'h8888_8888, 0, 1, ex(1, 32'h4444_4444, 2, 32'h7777_7777, 1));
    tbl[18] = mk(1, 0, 1, 32'h0,         0, 1, ex(1, 32'h4444_4444, 2, 32'h8888_8888, 1));
    tbl[19] = mk(1, 0, 0, 32'h0,         0, 1, ex(0, 32'h4444_4444, 2, 32'h0, 0));
    // reset mid-stream with a push and pop attempted in the reset cycle
    tbl[20] = mk(0, 1, 1, 32'hDEAD_BEEF, 1, 1, ex(0, 32'h4444_4444, 2, 32'h0, 0));
    tbl[21] = mk(1, 0, 0, 32'h0,         1, 1, ex(1, 32'h0, 0, 32'h0, 0));
    tbl[22] = mk(1, 0, 1, 32'h0,         1, 1, ex(1, 32'h0, 0, 32'h0, 0));
    // port 1 stall then drain
    tbl[23] = mk(1, 1, 1, 32'h9999_9999, 1, 0, ex(1, 32'h0, 0, 32'h0, 0));
    tbl[24] = mk(1, 0, 1, 32'h0,         1, 0, ex(1, 32'h0, 0, 32'h9999_9999, 1));
    tbl[25] = mk(1, 0, 1, 32'h0,         1, 1, ex(1, 32'h0, 0, 32'h9999_9999, 1));
    tbl[26] = mk(1, 0, 1, 32'h0,         1, 1, ex(1, 32'h0, 0, 32'h0, 0));

    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].rst_n, tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1);
      cmp($sformatf("vec%0d", i), observed(), tbl[i].exp);
    end

    // streaming on port 1: each word appears the cycle after it is accepted
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 1, 32'hC000_0000 + 32'(i), 1, 1);
      if (i == 0) cmp("stream0", observed(), ex(1, 32'h0, 0, 32'h0, 0));
      else        cmp($sformatf("stream%0d", i), observed(),
                      ex(1, 32'h0, 0, 32'hC000_0000 + 32'(i - 1), 1));
    end
    drive(1, 0, 1, 32'h0, 1, 1);
    cmp("stream_last", observed(), ex(1, 32'h0, 0, 32'hC000_0007, 1));
    drive(1, 0, 1, 32'h0, 1, 1);
    cmp("stream_idle", observed(), ex(1, 32'h0, 0, 32'h0, 0));

`ifdef ROUTE_DEMUX2_32_CNT_EN
    // 70001 pushes give 70000 pops on port 1 (plus earlier traffic): must saturate
    for (int i = 0; i < 70001; i++) drive(1, 1, 1, 32'(i), 1, 1);
    drive(1, 1, 1, 32'h1234_5678, 1, 1);
    cmp("cnt1_sat", 71'(cnt1), 71'(16'hFFFF));
    cnt_clr = 1'b1;
    drive(1, 1, 1, 32'h1234_5679, 1, 1);
    cnt_clr = 1'b0;
    cmp("cnt1_clr", 71'(cnt1), 71'(16'h0000));
    drive(1, 0, 1, 32'h0, 1, 1);
    cmp("cnt1_after_clr", 71'(cnt1), 71'(16'h0001));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
